joy_db15_tx: RTL and testbench

- Device-side responder for the DB15 serial joystick link: emulates the adapter's parallel-in/serial-out shift chain.
- Answers host JOY_LOAD/JOY_CLK strobes by shifting two players' button states out on JOY_DATA.
- Used as a loopback model on USER_IN/USER_OUT to exercise the host DB15 reader, and as the firmware of a standalone adapter build.
- Host strobes are asynchronous to clk; the block synchronises them.

---
 rtl/joy_db15_tx.sv | 150 +++++++++++++++
 tb/tb_joy_db15_tx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/joy_db15_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | joy_db15_tx : DB15 joystick adapter emulation, PISO shift responder   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module joy_db15_tx #(
  parameter int NBITS       = 12,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER      = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             joy_clk,
  input  logic             joy_load,
  input  logic [NBITS-1:0] joystick1,
  input  logic [NBITS-1:0] joystick2,
  output logic             joy_data,
  output logic [4:0]       bit_index,
  output logic             active,
  output logic             frame_done,
  output logic             overrun
);

  localparam int         FW       = 2 * NBITS;
  localparam int         CW       = (FILTER > 1) ? $clog2(FILTER) : 1;
  localparam logic [4:0] LAST_IDX = 5'(FW - 1);
  localparam logic [4:0] FULL_IDX = 5'(FW);

  if (FW > 31 || NBITS < 1) begin : g_bad_nbits
    $error("joy_db15_tx: 2*NBITS must be in 2..31");
  end
  if (SYNC_STAGES < 1 || FILTER < 1) begin : g_bad_filter
    $error("joy_db15_tx: SYNC_STAGES and FILTER must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  // Index 1 carries joy_load, index 0 carries joy_clk.
  logic [1:0] raw_strobe;
  logic [1:0] strobe_f;
  assign raw_strobe = {joy_load, joy_clk};

  for (genvar g = 0; g < 2; g++) begin : g_strobe
    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   level;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync  <= '1;
        cnt   <= '0;
        level <= 1'b1;
      end else begin
        sync[0] <= raw_strobe[g];
        for (int k = 1; k < SYNC_STAGES; k++) sync[k] <= sync[k-1];
        if (sync[SYNC_STAGES-1] == level) begin
          cnt <= '0;
        end else if (cnt == CW'(FILTER - 1)) begin
          level <= sync[SYNC_STAGES-1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end

    assign strobe_f[g] = level;
  end

  logic ld_f, ck_f, ck_f_d, ck_rise;
  assign ld_f    = strobe_f[1];
  assign ck_f    = strobe_f[0];
  assign ck_rise = ck_f & ~ck_f_d;

  state_t         state, state_nxt;
  logic [FW-1:0]  sreg, sreg_nxt;
  logic [4:0]     idx_nxt;
  logic           ovr_nxt, done_nxt;
  logic           done_seen, seen_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      sreg       <= '1;
      joy_data   <= 1'b1;
      bit_index  <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      done_seen  <= 1'b0;
      ck_f_d     <= 1'b1;
    end else begin
      state      <= state_nxt;
      sreg       <= sreg_nxt;
      joy_data   <= sreg_nxt[0];
      bit_index  <= idx_nxt;
      frame_done <= done_nxt;
      overrun    <= ovr_nxt;
      done_seen  <= seen_nxt;
      ck_f_d     <= ck_f;
    end
  end

  // Load dominates everything; shift clocks only matter once ld_f is high.
  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    idx_nxt   = bit_index;
    ovr_nxt   = overrun;
    done_nxt  = 1'b0;
    seen_nxt  = done_seen;
    if (!ld_f) begin
      state_nxt = S_LOAD;
      sreg_nxt  = {~joystick2, ~joystick1};
      idx_nxt   = '0;
      ovr_nxt   = 1'b0;
    end else begin
      case (state)
        S_LOAD: state_nxt = S_SHIFT;
        S_SHIFT: begin
          if (ck_rise) begin
            sreg_nxt = {1'b1, sreg[FW-1:1]};
            idx_nxt  = bit_index + 5'd1;
            if (bit_index == LAST_IDX) begin
              done_nxt  = 1'b1;
              seen_nxt  = 1'b1;
              state_nxt = S_IDLE;
            end
          end
        end
        S_IDLE: begin
          // Clocks past the end of a completed frame read idle 1s.
          if (ck_rise && done_seen) begin
            sreg_nxt = {1'b1, sreg[FW-1:1]};
            ovr_nxt  = 1'b1;
            idx_nxt  = FULL_IDX;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign active = (state == S_SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_joy_db15_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_joy_db15_tx : scoreboard bench for the DB15 joystick responder     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_joy_db15_tx;

  localparam int K_DATA = 0;
  localparam int K_IDX  = 1;
  localparam int K_ACT  = 2;
  localparam int K_OVR  = 3;
  localparam int K_FD   = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        joy_clk = 1'b1;
  logic        joy_load = 1'b1;
  logic [11:0] joystick1 = '0;
  logic [11:0] joystick2 = '0;
  logic        joy_data, active, frame_done, overrun;
  logic [4:0]  bit_index;

  int    tests = 0;
  int    fails = 0;
  int    fd_cnt = 0;
  int    kind_q[$];
  int    exp_q[$];
  string name_q[$];

  joy_db15_tx #(.NBITS(12), .SYNC_STAGES(2), .FILTER(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .joy_clk    (joy_clk),
    .joy_load   (joy_load),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .joy_data   (joy_data),
    .bit_index  (bit_index),
    .active     (active),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (frame_done) fd_cnt++;

  initial begin : monitor
    int    k, e, act;
    string n;
    forever begin
      wait (kind_q.size() != 0);
      @(negedge clk);
      k = kind_q.pop_front();
      e = exp_q.pop_front();
      n = name_q.pop_front();
      case (k)
        K_DATA:  act = int'(joy_data);
        K_IDX:   act = int'(bit_index);
        K_ACT:   act = int'(active);
        K_OVR:   act = int'(overrun);
        default: act = fd_cnt;
      endcase
      tests++;
      if (act != e) begin
        fails++;
        $display("FAIL %s: got %0d, expected %0d", n, act, e);
      end
    end
  end

  task automatic expect_val(input int kind, input int exp, input string name);
    int t = 0;
    kind_q.push_back(kind);
    exp_q.push_back(exp);
    name_q.push_back(name);
    while (kind_q.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    if (kind_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s: monitor timeout, got no sample, expected %0d", name, exp);
      kind_q.delete();
      exp_q.delete();
      name_q.delete();
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clk_pulse();
    joy_clk = 1'b1;
    wait_clk(8);
    joy_clk = 1'b0;
    wait_clk(8);
  endtask

  task automatic load_pulse();
    joy_load = 1'b0;
    wait_clk(8);
    joy_load = 1'b1;
    wait_clk(8);
  endtask

  initial begin : stim
    logic [23:0] exp1;
    exp1 = 24'h7F_FFFA;   // {~12'h800, ~12'h005}

    wait_clk(5);
    expect_val(K_DATA, 1, "reset joy_data");
    expect_val(K_IDX,  0, "reset bit_index");
    expect_val(K_ACT,  0, "reset active");
    expect_val(K_OVR,  0, "reset overrun");
    expect_val(K_FD,   0, "reset frame_done count");
    reset_n = 1'b1;
    wait_clk(10);
    expect_val(K_DATA, 1, "post-reset joy_data");
    expect_val(K_ACT,  0, "post-reset active");

    joy_clk = 1'b0;
    wait_clk(8);
    clk_pulse();
    expect_val(K_OVR,  0, "clk from reset overrun");
    expect_val(K_IDX,  0, "clk from reset bit_index");
    expect_val(K_DATA, 1, "clk from reset joy_data");

    joystick1 = 12'h005;
    joystick2 = 12'h800;
    load_pulse();
    expect_val(K_ACT, 1, "frame1 active");
    expect_val(K_IDX, 0, "frame1 bit_index start");
    expect_val(K_DATA, int'(exp1[0]), "frame1 bit0");
    for (int i = 1; i < 24; i++) begin
      clk_pulse();
      expect_val(K_DATA, int'(exp1[i]), $sformatf("frame1 bit%0d", i));
      expect_val(K_IDX, i, $sformatf("frame1 bit_index%0d", i));
    end
    expect_val(K_FD,  0, "frame1 no early frame_done");
    expect_val(K_ACT, 1, "frame1 active before last");
    clk_pulse();
    expect_val(K_FD,   1, "frame1 frame_done count");
    expect_val(K_IDX,  24, "frame1 bit_index end");
    expect_val(K_ACT,  0, "frame1 active end");
    expect_val(K_DATA, 1, "frame1 joy_data idle");

    for (int i = 0; i < 3; i++) begin
      clk_pulse();
      expect_val(K_DATA, 1, $sformatf("overrun joy_data%0d", i));
      expect_val(K_IDX, 24, $sformatf("overrun bit_index%0d", i));
    end
    expect_val(K_OVR, 1, "overrun flag");
    expect_val(K_FD,  1, "overrun no extra frame_done");
    joystick1 = 12'h000;
    joystick2 = 12'h000;
    load_pulse();
    expect_val(K_OVR,  0, "overrun cleared by load");
    expect_val(K_IDX,  0, "frame2 bit_index start");
    expect_val(K_DATA, 1, "frame2 bit0");

    for (int i = 0; i < 5; i++) clk_pulse();
    expect_val(K_IDX, 5, "abort bit_index before reload");
    joystick1 = 12'hFFF;
    load_pulse();
    expect_val(K_IDX,  0, "abort bit_index reload");
    expect_val(K_ACT,  1, "abort active");
    expect_val(K_DATA, 0, "abort bit0");
    for (int i = 1; i < 12; i++) begin
      clk_pulse();
      expect_val(K_DATA, 0, $sformatf("abort bit%0d", i));
    end
    clk_pulse();
    expect_val(K_DATA, 1, "abort bit12");
    expect_val(K_FD,   1, "abort no frame_done");

    joy_load = 1'b0;
    wait_clk(8);
    for (int i = 0; i < 3; i++) clk_pulse();
    expect_val(K_IDX, 0, "dominance bit_index");
    expect_val(K_ACT, 0, "dominance active");
    joystick1 = 12'h001;
    wait_clk(8);
    expect_val(K_DATA, 0, "load tracks 001");
    joystick1 = 12'h000;
    wait_clk(8);
    expect_val(K_DATA, 1, "load tracks 000");
    joystick1 = 12'h001;
    wait_clk(8);
    joy_load = 1'b1;
    wait_clk(8);
    joystick1 = 12'h000;
    wait_clk(8);
    expect_val(K_DATA, 0, "freeze bit0");
    expect_val(K_ACT,  1, "freeze active");
    clk_pulse();
    expect_val(K_IDX, 1, "freeze bit_index1");

    joy_load = 1'b0;
    wait_clk(1);
    joy_load = 1'b1;
    wait_clk(10);
    expect_val(K_IDX, 1, "load glitch bit_index");
    expect_val(K_ACT, 1, "load glitch active");
    joy_clk = 1'b1;
    wait_clk(1);
    joy_clk = 1'b0;
    wait_clk(10);
    expect_val(K_IDX, 1, "clk glitch bit_index");

    joystick1 = 12'h0F0;
    load_pulse();
    for (int i = 0; i < 3; i++) clk_pulse();
    expect_val(K_IDX, 3, "pre-reset bit_index");
    joy_clk = 1'b1;
    wait_clk(2);
    #3 reset_n = 1'b0;
    expect_val(K_DATA, 1, "mid reset joy_data");
    expect_val(K_IDX,  0, "mid reset bit_index");
    expect_val(K_ACT,  0, "mid reset active");
    expect_val(K_OVR,  0, "mid reset overrun");
    wait_clk(2);
    reset_n = 1'b1;
    wait_clk(12);
    expect_val(K_DATA, 1, "after reset joy_data");
    expect_val(K_IDX,  0, "after reset bit_index");
    expect_val(K_ACT,  0, "after reset active");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
